display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed driver for the 8-digit, common-anode 7-segment display. It sits directly downstream of the clock interface and consumes its eight 6-bit digit words d1..d8. Each frame it snapshots all eight words, scans one digit at a time with a blanking gap between digits, and drives registered, active-low anode and segment outputs to the board.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot. At 100 MHz this gives 1 ms per slot and a 125 Hz frame rate. Must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 1000: cycles at the start of each slot during which all digits are dark. Suppresses ghosting. Range 0..REFRESH_DIV-2.

- clock  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- d1..d8  in  6 each  digit word {en, val[3:0], dp}
  - en=1 lights the digit.
  - val is a hex digit.
  - dp is the active-low decimal point (1 = off).
  - d1 is the rightmost digit, d8 the leftmost.
- an  out  8  active-low anode enables; an[k] drives digit d(k+1)
- dec_ddp  out  8  active-low segments {a,b,c,d,e,f,g,dp}, with a at bit 7

## Operation
- **Slot counter:** cnt, width $clog2(REFRESH_DIV), runs 0..REFRESH_DIV-1 and wraps.
- **Digit index:** idx, 3 bits, runs 0..7. It increments when cnt==REFRESH_DIV-1 and wraps 7→0.
- **Phase FSM** (state is a function of cnt):
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt ≥ BLANK_CYCLES.
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK on the slot wrap.
  - With BLANK_CYCLES=0 the FSM stays in SHOW permanently.
- **Frame snapshot:** on the edge where idx==7 and cnt==REFRESH_DIV-1, the frame registers f1..f8 load d1..d8.
  - Input changes during a frame never appear until the next frame, so there is no tearing.
  - There is no handshake; inputs are sampled only at that edge.
- **Output selection**, with fsel = f(idx+1):
  - BLANK: an=8'hFF, dec_ddp=8'hFF.
  - SHOW with fsel.en=0: an=8'hFF, dec_ddp=8'hFF.
  - SHOW with fsel.en=1: an = ~(1<<idx) and dec_ddp = {seg(fsel.val), fsel.dp}.
- **seg() lit segments** (lit segment = 0 in the output):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
  - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
  - C adef, d bcdeg, E adefg, F aefg
- **Reset (asynchronous, any time including mid-slot):**
  - cnt=0, idx=0, f1..f8=0.
  - an=8'hFF, dec_ddp=8'hFF immediately.
  - Because the frame registers clear to 0, the whole first frame after release is dark. The first snapshot occurs 8·REFRESH_DIV cycles after release.
- The outputs never select two anodes at once. an is one-hot-low or all-ones in every cycle.

## Timing
- an and dec_ddp are registered. They reflect the (cnt, idx, frame) state of the previous cycle, i.e. one cycle of latency.
- Slot k (idx=k) drives outputs for REFRESH_DIV consecutive cycles, delayed by one cycle:
  - the first BLANK_CYCLES of those cycles are dark;
  - the remaining REFRESH_DIV−BLANK_CYCLES cycles show the digit.
- Frame period is 8·REFRESH_DIV cycles.
- A snapshot taken at the end of frame N is first visible, after blanking, in slot 0 of frame N+1.
- Simultaneous events: a slot wrap and a snapshot on the same edge are legal. The output register on that edge still uses the old frame and old idx=7.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2 (frame = 64 cycles).

1. **Reset and first frame:** hold reset low, set d1..d8={1,4'h8,0}. Required: an=8'hFF and dec_ddp=8'hFF during reset and for the first 64 cycles after release. In frame 2, every slot shows an one-hot-low with dec_ddp=8'h00.
2. **Single-digit decode:** d1={1,4'd3,1}, others en=0. Required in frame 2:
   - slot 0: 2 cycles an=8'hFF, then 6 cycles an=8'hFE with dec_ddp=8'h0D;
   - slots 1..7: an=8'hFF.
3. **Decimal point and disabled digit:** d2={1,4'd0,0}, d6={0,4'h5,1}. Required:
   - slot 1 shows an=8'hFD, dec_ddp=8'h02;
   - slot 5 keeps an=8'hFF throughout.
4. **Hex sweep:** step d8.val through 0..F, one value per frame with en=1, dp=1. Required: slot 7 shows an=8'h7F and dec_ddp matching the seg() list for every value (e.g. A→8'h11, F→8'h71).
5. **No tearing:** in frame 2 slot 3, change d8 from {1,4'h1,1} to {1,4'h7,1}. Required: slot 7 of frame 2 still shows 8'h9F; slot 7 of frame 3 shows 8'h1F.
6. **Mid-slot reset:** assert reset at cnt=5, idx=4 while that digit is lit. Required: an=8'hFF and dec_ddp=8'hFF with no clock edge needed; after release, cnt and idx restart at 0 and the first frame is dark.

Source files
------------

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// It snapshots d1..d8 once per frame, blanks the start of each slot, and drives registered active-low outputs.
module display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_ddp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BlankLim = CW'(BLANK_CYCLES);

  typedef enum logic {BLANK, SHOW} phase_e;

  phase_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  frame_q [8];
  logic [5:0]  din     [8];
  logic [5:0]  fsel;
  logic [7:0]  an_q, an_d;
  logic [7:0]  dec_q, dec_d;
  logic        slotEnd, snapshot;

  assign din[0] = d1;
  assign din[1] = d2;
  assign din[2] = d3;
  assign din[3] = d4;
  assign din[4] = d5;
  assign din[5] = d6;
  assign din[6] = d7;
  assign din[7] = d8;

  assign slotEnd  = (cnt_q == CntLast);
  assign snapshot = slotEnd && (idx_q == 3'd7);
  assign cnt_d    = slotEnd ? '0 : cnt_q + 1'b1;
  assign idx_d    = slotEnd ? idx_q + 3'd1 : idx_q;
  assign fsel     = frame_q[idx_q];

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
  endfunction

  // The phase always tracks cnt, so it restarts in BLANK unless blanking is disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      dec_q   <= 8'hFF;
      for (int i = 0; i < 8; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dec_q   <= dec_d;
      if (snapshot) begin
        for (int i = 0; i < 8; i++) frame_q[i] <= din[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_d == BlankLim) state_d = SHOW;
      SHOW:    if (slotEnd && (BLANK_CYCLES != 0)) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    an_d  = 8'hFF;
    dec_d = 8'hFF;
    if (state_q == SHOW && fsel[5]) begin
      an_d  = ~(8'b1 << idx_q);
      dec_d = {seg(fsel[4:1]), fsel[0]};
    end
  end

  assign an      = an_q;
  assign dec_ddp = dec_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with REFRESH_DIV=8, BLANK_CYCLES=2 (64-cycle frame).
module tb_display_scanner;

  logic       clock;
  logic       reset;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0] an, dec_ddp;

  int compared;
  int mismatched;
  int edgeCount;

  display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .an(an), .dec_ddp(dec_ddp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // edgeCount = number of rising edges since reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) edgeCount <= 0;
    else        edgeCount <= edgeCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] v1, v2, v3, v4, v5, v6, v7, v8);
    d1 = v1; d2 = v2; d3 = v3; d4 = v4; d5 = v5; d6 = v6; d7 = v7; d8 = v8;
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_an", an, 8'hFF);
    checkOutput("rst_dec", dec_ddp, 8'hFF);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Outputs seen just after edge 64f+8s+c+1 belong to frame f, slot s, slot cycle c.
  task automatic waitFor(input int f, input int s, input int c);
    int target;
    target = 64 * f + 8 * s + c + 1;
    if (edgeCount > target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL waitFor: edge %0d already passed target %0d", edgeCount, target);
    end
    while (edgeCount < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkDarkFrame(input int f, input string tag);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        waitFor(f, s, c);
        checkOutput({tag, "_an"}, an, 8'hFF);
        checkOutput({tag, "_dec"}, dec_ddp, 8'hFF);
      end
    end
  endtask

  logic [7:0] hexExp [16];

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    hexExp = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    applyStimulus(6'h30, 6'h30, 6'h30, 6'h30, 6'h30, 6'h30, 6'h30, 6'h30);

    $display("[TB] reset and first frame");
    applyReset();
    checkDarkFrame(0, "t1_dark");
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        waitFor(1, s, c);
        checkOutput("t1_an", an, (c < 2) ? 8'hFF : ~(8'b1 << s));
        checkOutput("t1_dec", dec_ddp, (c < 2) ? 8'hFF : 8'h00);
      end
    end

    $display("[TB] single-digit decode");
    applyStimulus(6'h27, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    applyReset();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        waitFor(1, s, c);
        checkOutput("t2_an", an, (s == 0 && c >= 2) ? 8'hFE : 8'hFF);
        checkOutput("t2_dec", dec_ddp, (s == 0 && c >= 2) ? 8'h0D : 8'hFF);
      end
    end

    $display("[TB] decimal point and disabled digit");
    applyStimulus(6'h00, 6'h20, 6'h00, 6'h00, 6'h00, 6'h0B, 6'h00, 6'h00);
    applyReset();
    for (int c = 0; c < 8; c++) begin
      waitFor(1, 1, c);
      checkOutput("t3_s1_an", an, (c >= 2) ? 8'hFD : 8'hFF);
      checkOutput("t3_s1_dec", dec_ddp, (c >= 2) ? 8'h02 : 8'hFF);
    end
    for (int c = 0; c < 8; c++) begin
      waitFor(1, 5, c);
      checkOutput("t3_s5_an", an, 8'hFF);
    end

    $display("[TB] hex sweep");
    applyStimulus(6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    applyReset();
    for (int v = 0; v < 16; v++) begin
      waitFor(v, 7, 5);
      d8 = {1'b1, 4'(v), 1'b1};
      waitFor(v + 1, 7, 1);
      checkOutput("t4_blank_an", an, 8'hFF);
      waitFor(v + 1, 7, 4);
      checkOutput("t4_an", an, 8'h7F);
      checkOutput("t4_dec", dec_ddp, hexExp[v]);
    end

    $display("[TB] no tearing");
    applyStimulus(6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23);
    applyReset();
    waitFor(1, 3, 2);
    d8 = 6'h2F;
    waitFor(1, 7, 4);
    checkOutput("t5_old_an", an, 8'h7F);
    checkOutput("t5_old_dec", dec_ddp, 8'h9F);
    waitFor(2, 7, 4);
    checkOutput("t5_new_an", an, 8'h7F);
    checkOutput("t5_new_dec", dec_ddp, 8'h1F);

    $display("[TB] mid-slot reset");
    applyStimulus(6'h00, 6'h00, 6'h00, 6'h00, 6'h25, 6'h00, 6'h00, 6'h00);
    applyReset();
    waitFor(1, 4, 4);
    checkOutput("t6_lit_an", an, 8'hEF);
    checkOutput("t6_lit_dec", dec_ddp, 8'h25);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_an", an, 8'hFF);
    checkOutput("t6_async_dec", dec_ddp, 8'hFF);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkDarkFrame(0, "t6_dark");
    waitFor(1, 4, 1);
    checkOutput("t6_restart_blank", an, 8'hFF);
    waitFor(1, 4, 2);
    checkOutput("t6_restart_an", an, 8'hEF);
    checkOutput("t6_restart_dec", dec_ddp, 8'h25);
    waitFor(1, 5, 4);
    checkOutput("t6_after_an", an, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
